// File: rtl/traffic_light_ctrl_pkg.sv
// Shared types and helpers for the multi-phase traffic-light sequencer.
// The FLASH encoding is reserved even when TRAFFIC_FLASH_EN is not defined.
package traffic_pkg;

    localparam int MAX_PHASES = 8;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        AMBER   = 2'd2,
        FLASH   = 2'd3
    } state_t;

    function automatic int phase_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Scans req from current+1, wraps modulo n, and returns the first requesting phase.
    function automatic logic next_phase(
        input  logic [MAX_PHASES-1:0] req,
        input  logic [2:0]            current,
        input  int                    n,
        output logic [2:0]            phase
    );
        logic found;
        int   idx;
        found = 1'b0;
        phase = current;
        idx   = 0;
        for (int i = 1; i <= MAX_PHASES; i++) begin
            if ((i <= n) && !found) begin
                idx = (int'(current) + i) % n;
                if (req[idx[2:0]]) begin
                    found = 1'b1;
                    phase = idx[2:0];
                end
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Supervisor-to-sequencer bundle: timebase, demand and hold in; lamps and status out.
// The flash request is present only when TRAFFIC_FLASH_EN is defined.
interface traffic_light_ctrl_if #(
    parameter int NUM_PHASES = 2
);
    import traffic_pkg::*;

    localparam int PHASE_W = phase_width(NUM_PHASES);

    logic                  tic;
    logic                  hold;
    logic [NUM_PHASES-1:0] req;
    logic [NUM_PHASES-1:0] red;
    logic [NUM_PHASES-1:0] amber;
    logic [NUM_PHASES-1:0] green;
    logic [PHASE_W-1:0]    active_phase;
    logic [1:0]            state_o;
`ifdef TRAFFIC_FLASH_EN
    logic                  flash;
`endif

    modport master (
`ifdef TRAFFIC_FLASH_EN
        output flash,
`endif
        output tic, hold, req,
        input  red, amber, green, active_phase, state_o
    );

    modport slave (
`ifdef TRAFFIC_FLASH_EN
        input  flash,
`endif
        input  tic, hold, req,
        output red, amber, green, active_phase, state_o
    );

endinterface

// File: rtl/traffic_light_ctrl_tic_counter.sv
// Duration counter paced by the external tic strobe; expire flags the last counted tic.
// hold freezes the count and masks expiry, so a held final tic is deferred.
module tic_counter #(
    parameter int TIC_W     = 16,
    parameter int RESET_VAL = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [TIC_W-1:0] load_val,
    input  logic             tic,
    input  logic             hold,
    output logic             expire
);

    logic [TIC_W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= TIC_W'(RESET_VAL);
        end else if (load) begin
            count_q <= load_val;
        end else if (tic && !hold && (count_q != TIC_W'(1))) begin
            count_q <= count_q - TIC_W'(1);
        end
    end

    assign expire = tic && !hold && (count_q == TIC_W'(1));

endmodule

// File: rtl/traffic_light_ctrl.sv
// Round-robin GREEN -> AMBER -> ALL_RED sequencer with registered lamp outputs.
// Defining TRAFFIC_FLASH_EN adds the flash request and the flashing-amber FLASH state.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES   = 2,
    parameter int TIC_W        = 16,
    parameter int GREEN_TICS   = 200,
    parameter int AMBER_TICS   = 30,
    parameter int ALL_RED_TICS = 10,
    parameter int FLASH_TICS   = 50
) (
    input logic                 clock,
    input logic                 reset,
    traffic_light_ctrl_if.slave bus
);

    localparam int PHASE_W = phase_width(NUM_PHASES);

    generate
        if (NUM_PHASES < 2 || NUM_PHASES > MAX_PHASES) begin : g_bad_phases
            $error("traffic_light_ctrl: NUM_PHASES out of range");
        end
        if (GREEN_TICS < 1 || AMBER_TICS < 1 || ALL_RED_TICS < 1 || FLASH_TICS < 1) begin : g_bad_tics
            $error("traffic_light_ctrl: durations must be at least one tic");
        end
        if (GREEN_TICS >= 2**TIC_W || AMBER_TICS >= 2**TIC_W ||
            ALL_RED_TICS >= 2**TIC_W || FLASH_TICS >= 2**TIC_W) begin : g_bad_width
            $error("traffic_light_ctrl: a duration does not fit in TIC_W bits");
        end
    endgenerate

    state_t                state_q, state_d;
    logic [PHASE_W-1:0]    phase_q, phase_d;
    logic                  flash_amber_q, flash_amber_d;
    logic [NUM_PHASES-1:0] red_q, red_d;
    logic [NUM_PHASES-1:0] amber_q, amber_d;
    logic [NUM_PHASES-1:0] green_q, green_d;
    logic [MAX_PHASES-1:0] req_ext;
    logic                  rr_found;
    logic [2:0]            rr_phase;
    logic                  load;
    logic [TIC_W-1:0]      load_val;
    logic                  expire;

    tic_counter #(
        .TIC_W     (TIC_W),
        .RESET_VAL (ALL_RED_TICS)
    ) u_tic_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .tic      (bus.tic),
        .hold     (bus.hold),
        .expire   (expire)
    );

    always_comb begin
        req_ext = '0;
        req_ext[NUM_PHASES-1:0] = bus.req;
    end

    // Next state, counter reload and next lamp pattern; lamps follow the next state so they register with it.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        flash_amber_d = flash_amber_q;
        load          = 1'b0;
        load_val      = TIC_W'(ALL_RED_TICS);
        rr_phase      = 3'd0;
        rr_found      = next_phase(req_ext, 3'(phase_q), NUM_PHASES, rr_phase);

        case (state_q)
            GREEN: begin
                if (expire) begin
                    state_d  = AMBER;
                    load     = 1'b1;
                    load_val = TIC_W'(AMBER_TICS);
                end
            end
            AMBER: begin
                if (expire) begin
                    state_d  = ALL_RED;
                    load     = 1'b1;
                    load_val = TIC_W'(ALL_RED_TICS);
                end
            end
            ALL_RED: begin
                if (expire) begin
                    load = 1'b1;
                    if (rr_found) begin
                        state_d  = GREEN;
                        phase_d  = PHASE_W'(rr_phase);
                        load_val = TIC_W'(GREEN_TICS);
                    end else begin
                        load_val = TIC_W'(1);
                    end
                end
            end
            FLASH: begin
`ifdef TRAFFIC_FLASH_EN
                if (expire) begin
                    flash_amber_d = ~flash_amber_q;
                    load          = 1'b1;
                    load_val      = TIC_W'(FLASH_TICS);
                end
`else
                state_d  = ALL_RED;
                load     = 1'b1;
                load_val = TIC_W'(ALL_RED_TICS);
`endif
            end
            default: begin
                state_d  = ALL_RED;
                load     = 1'b1;
                load_val = TIC_W'(ALL_RED_TICS);
            end
        endcase

`ifdef TRAFFIC_FLASH_EN
        if (bus.flash) begin
            if (state_q != FLASH) begin
                state_d       = FLASH;
                flash_amber_d = 1'b1;
                load          = 1'b1;
                load_val      = TIC_W'(FLASH_TICS);
            end
        end else if (state_q == FLASH) begin
            state_d  = ALL_RED;
            load     = 1'b1;
            load_val = TIC_W'(ALL_RED_TICS);
        end
`endif

        green_d = '0;
        amber_d = '0;
        case (state_d)
            GREEN:   green_d[phase_d] = 1'b1;
            AMBER:   amber_d[phase_d] = 1'b1;
            FLASH:   amber_d = {NUM_PHASES{flash_amber_d}};
            default: ;
        endcase
        red_d = (state_d == FLASH) ? '0 : ~(green_d | amber_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ALL_RED;
            phase_q       <= PHASE_W'(NUM_PHASES - 1);
            flash_amber_q <= 1'b0;
            red_q         <= '1;
            amber_q       <= '0;
            green_q       <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            flash_amber_q <= flash_amber_d;
            red_q         <= red_d;
            amber_q       <= amber_d;
            green_q       <= green_d;
        end
    end

    assign bus.red          = red_q;
    assign bus.amber        = amber_q;
    assign bus.green        = green_q;
    assign bus.active_phase = phase_q;
    assign bus.state_o      = state_q;

endmodule
